card_row_display: RTL
=====================

Name: card_row_display

Overview:
- Parametrised successor to the single-card table renderer.
- Draws a horizontal row of NUM_SLOTS card slots on the green table. Each slot tracks EMPTY / FACE_DOWN / FACE_UP.
- A cursor selects a slot and is drawn as a blinking yellow border. Button edges deal, flip, clear and move the cursor.
- Sits between the button debouncers / VGA timing generator and the VGA RGB output pins.

Parameters:
- NUM_SLOTS, 4, number of card slots (2..8).
- CARD_W, 75, card width in pixels (hCount axis).
- CARD_H, 75, card height in pixels (vCount axis).
- SLOT_X0, 225, hCount of left edge of slot 0.
- SLOT_PITCH, 100, hCount distance between left edges of adjacent slots; must be > CARD_W + 2*BORDER.
- SLOT_Y, 350, vCount of top edge of all slots.
- BORDER, 3, cursor border thickness in pixels, drawn outside the card rectangle.
- BLINK_FRAMES, 30, frames per blink half-period.

Ports:
- clk  in  1  system clock; hCount/vCount/bright are synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- bright  in  1  high inside the visible area.
- up  in  1  debounced level; rising edge flips the selected card.
- down  in  1  debounced level; rising edge deals one card.
- left  in  1  debounced level; rising edge moves cursor left.
- right  in  1  debounced level; rising edge moves cursor right.
- hCount  in  10  current pixel column.
- vCount  in  10  current pixel row.
- rgb  out  12  registered pixel colour.
- background  out  12  constant table colour, 12'h0F0.
- cursor  out  clog2(NUM_SLOTS)  selected slot index.
- dealt  out  clog2(NUM_SLOTS+1)  number of non-EMPTY slots.

Behaviour:
- Reset (async, any time, including mid-frame or mid-press):
  - All slots EMPTY; cursor=0; dealt=0; rgb=0.
  - Blink phase on (border visible); frame counter=0.
  - Button history registers = 0, so a button held through reset produces one edge after release of rst.
- Edge detect: per button, prev register; edge = level & ~prev; one clk of action per press.
- Cursor:
  - left edge: cursor-1, wraps 0 -> NUM_SLOTS-1.
  - right edge: cursor+1, wraps NUM_SLOTS-1 -> 0.
  - left and right edges in the same cycle: no move.
- Deal (down edge alone):
  - Slot[dealt] <- FACE_DOWN; dealt+1.
  - If dealt==NUM_SLOTS (full): ignored, no state change.
  - Slots fill strictly left to right; dealt always equals the count of leading non-EMPTY slots.
- Flip (up edge alone):
  - If slot[cursor]==FACE_DOWN -> FACE_UP.
  - FACE_UP or EMPTY: ignored (no flip back).
- Clear (up and down edges in the same cycle): all slots EMPTY, dealt=0, cursor=0. Clear overrides deal/flip. Left/right in that same cycle are ignored.
- Move plus deal/flip in the same cycle:
  - Both apply.
  - Flip uses the cursor value before the move.
- Slot state, cursor and dealt update on the clk edge following the button edge. Outputs cursor and dealt are registered.
- Frame tick:
  - Tick is the rising edge of (hCount==0 && vCount==0), so a pixel-enable slower than clk still gives one tick per frame.
  - Frame counter runs 0..BLINK_FRAMES-1; on wrap, blink phase toggles.
- Render:
  - Card rect of slot i: SLOT_X0+i*SLOT_PITCH <= hCount < that+CARD_W, and SLOT_Y <= vCount < SLOT_Y+CARD_H.
  - Border rect: card rect grown by BORDER on all four sides.
  - Colour priority, highest first:
    1. ~bright -> 12'h000.
    2. Inside card rect of a FACE_UP slot -> 12'hFFF.
    3. Inside card rect of a FACE_DOWN slot -> 12'h00F.
    4. Inside border rect but outside card rect of slot==cursor, and blink phase on -> 12'hFF0.
    5. Otherwise -> 12'h0F0, including EMPTY slot interiors.
  - Cursor border is drawn regardless of slot state, so an EMPTY selected slot shows a green hole with a yellow frame.
  - Width: slot x offsets computed in 11 bits; any rect extending past hCount 1023 is clipped, not wrapped.
  - Latency: rgb is registered, exactly 1 clk after the corresponding hCount/vCount/bright. State changes take effect in rgb from the next pixel evaluated after the update.

Test Plan:
- Reset, then hold rst high while pulsing down -> dealt=0, cursor=0, rgb=000 throughout; after release, one down press -> dealt=1, slot0 pixel (230,360) = 00F.
- Four down presses, then a fifth (NUM_SLOTS=4) -> dealt stays 4; slot3 pixel (530,360) = 00F; no change on fifth.
- right x3 from cursor 0 -> cursor=3; right again -> 0; left -> 3; left+right same cycle -> stays 3.
- Deal 2, cursor=1, up -> pixel (330,360) = FFF; up again -> still FFF; cursor=3 (EMPTY), up -> no change, dealt=2.
- Press up+down in the same cycle with 3 dealt, cursor=2 -> dealt=0, cursor=0, all card pixels 0F0.
- Blink: cursor=0; pixel (223,360) = FF0 for frames 0..29, 0F0 for frames 30..59, FF0 again at frame 60; pixel with bright=0 -> 000; rgb lags hCount by 1 clk.

Source files
------------

// File: rtl/card_row_display_if.sv
// rtl/card_row_display_if.sv - button, pixel-position and colour bundle for card_row_display
interface card_row_display_if #(
  parameter int NUM_SLOTS = 4
);
  localparam int CW = $clog2(NUM_SLOTS);
  localparam int DW = $clog2(NUM_SLOTS + 1);

  logic          bright;
  logic          up;
  logic          down;
  logic          left;
  logic          right;
  logic [9:0]    hCount;
  logic [9:0]    vCount;
  logic [11:0]   rgb;
  logic [11:0]   background;
  logic [CW-1:0] cursor;
  logic [DW-1:0] dealt;

  modport master (
    output bright, up, down, left, right, hCount, vCount,
    input  rgb, background, cursor, dealt
  );

  modport slave (
    input  bright, up, down, left, right, hCount, vCount,
    output rgb, background, cursor, dealt
  );
endinterface

// File: rtl/card_row_display.sv
// rtl/card_row_display.sv - row of card slots with blinking cursor, driven by button edges
module card_row_display #(
  parameter int NUM_SLOTS    = 4,
  parameter int CARD_W       = 75,
  parameter int CARD_H       = 75,
  parameter int SLOT_X0      = 225,
  parameter int SLOT_PITCH   = 100,
  parameter int SLOT_Y       = 350,
  parameter int BORDER       = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  card_row_display_if.slave  bus
);
  localparam int CW = $clog2(NUM_SLOTS);
  localparam int DW = $clog2(NUM_SLOTS + 1);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, FACE_DOWN = 2'd1, FACE_UP = 2'd2} slot_t;

  slot_t         slot_q [NUM_SLOTS];
  logic [CW-1:0] cursor_q;
  logic [DW-1:0] dealt_q;
  logic [3:0]    btn, btn_prev, btn_edge;
  logic          up_e, down_e, left_e, right_e;
  logic          clear, deal, flip, move_l, move_r, sel_face_down;
  logic          origin, origin_prev, tick;
  logic [FW-1:0] frame_q;
  logic          blink_q;
  logic [11:0]   pix_color, rgb_q;

  assign btn      = {bus.up, bus.down, bus.left, bus.right};
  assign btn_edge = btn & ~btn_prev;
  assign up_e     = btn_edge[3];
  assign down_e   = btn_edge[2];
  assign left_e   = btn_edge[1];
  assign right_e  = btn_edge[0];

  always_comb begin
    sel_face_down = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (cursor_q == CW'(i) && slot_q[i] == FACE_DOWN) sel_face_down = 1'b1;
  end

  // up+down together is a clear and swallows every other action that cycle
  assign clear  = up_e & down_e;
  assign deal   = down_e & ~up_e & (dealt_q < DW'(NUM_SLOTS));
  assign flip   = up_e & ~down_e & sel_face_down;
  assign move_l = ~clear & left_e & ~right_e;
  assign move_r = ~clear & right_e & ~left_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= EMPTY;
      cursor_q <= '0;
      dealt_q  <= '0;
      btn_prev <= '0;
    end else begin
      btn_prev <= btn;
      if (clear) begin
        for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= EMPTY;
        cursor_q <= '0;
        dealt_q  <= '0;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (deal && dealt_q == DW'(i)) slot_q[i] <= FACE_DOWN;
          if (flip && cursor_q == CW'(i)) slot_q[i] <= FACE_UP;
        end
        if (deal) dealt_q <= dealt_q + DW'(1);
        if (move_l)
          cursor_q <= (cursor_q == '0) ? CW'(NUM_SLOTS - 1) : cursor_q - CW'(1);
        else if (move_r)
          cursor_q <= (cursor_q == CW'(NUM_SLOTS - 1)) ? '0 : cursor_q + CW'(1);
      end
    end
  end

  // Edge of the origin pixel, so a slow pixel enable still yields one tick per frame
  assign origin = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);
  assign tick   = origin & ~origin_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_prev <= 1'b0;
      frame_q     <= '0;
      blink_q     <= 1'b1;
    end else begin
      origin_prev <= origin;
      if (tick) begin
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_q <= '0;
          blink_q <= ~blink_q;
        end else begin
          frame_q <= frame_q + FW'(1);
        end
      end
    end
  end

  int   hx, vy, x0;
  logic hit_up, hit_down, hit_border, in_card, in_border;

  // Integer compares: rectangles running past column 1023 simply never match
  always_comb begin
    hx         = int'(bus.hCount);
    vy         = int'(bus.vCount);
    x0         = 0;
    in_card    = 1'b0;
    in_border  = 1'b0;
    hit_up     = 1'b0;
    hit_down   = 1'b0;
    hit_border = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      x0        = SLOT_X0 + i * SLOT_PITCH;
      in_card   = (hx >= x0) && (hx < x0 + CARD_W) &&
                  (vy >= SLOT_Y) && (vy < SLOT_Y + CARD_H);
      in_border = (hx >= x0 - BORDER) && (hx < x0 + CARD_W + BORDER) &&
                  (vy >= SLOT_Y - BORDER) && (vy < SLOT_Y + CARD_H + BORDER);
      if (in_card && slot_q[i] == FACE_UP)   hit_up   = 1'b1;
      if (in_card && slot_q[i] == FACE_DOWN) hit_down = 1'b1;
      if (in_border && !in_card && cursor_q == CW'(i)) hit_border = 1'b1;
    end
    if (hit_up)                     pix_color = 12'hFFF;
    else if (hit_down)              pix_color = 12'h00F;
    else if (hit_border && blink_q) pix_color = 12'hFF0;
    else                            pix_color = 12'h0F0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_q <= 12'h000;
    else     rgb_q <= bus.bright ? pix_color : 12'h000;
  end

  assign bus.rgb        = rgb_q;
  assign bus.background = 12'h0F0;
  assign bus.cursor     = cursor_q;
  assign bus.dealt      = dealt_q;
endmodule
